// File: rtl/data_bus_responder.sv
// data_bus_responder: data-port responder with word RAM, output FIFO, cycle counter and sticky status.
module data_bus_responder #(
  parameter int N = 32,
  parameter int RAM_WORDS = 64,
  parameter int FIFO_DEPTH = 8,
  parameter logic [N-1:0] IO_BASE = 32'h0000_1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MemWrite,
  input  logic [N-1:0] Addr,
  input  logic [N-1:0] WriteData,
  output logic [N-1:0] ReadData,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [N-1:0] mem [RAM_WORDS];
  logic [N-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] cyc_q, cyc_d;
  logic [1:0] err_q, err_d;
  logic ram_sel, io_sel, empty, full, push_try, push, pop, wr_stat, wr_cyc, unm_set;
  logic [1:0] off;
  logic [N-1:0] status;
  logic unused_addr;
  assign unused_addr = ^Addr[1:0];
  always_comb begin
    ram_sel = Addr < N'(RAM_WORDS * 4);
    io_sel = Addr[N-1:4] == IO_BASE[N-1:4];
    off = Addr[3:2];
    empty = cnt_q == '0;
    full = cnt_q == CW'(FIFO_DEPTH);
    push_try = MemWrite && io_sel && off == 2'd0;
    push = push_try && !full;
    pop = !empty && out_ready;
    wr_stat = MemWrite && io_sel && off == 2'd1;
    wr_cyc = MemWrite && io_sel && off == 2'd2;
    unm_set = MemWrite && ((!ram_sel && !io_sel) || (io_sel && off == 2'd3));
    status = N'({8'(cnt_q), 4'b0, err_q, full, empty});
    out_valid = !empty;
    out_data = empty ? '0 : fifo[rd_q];
    ReadData = ram_sel ? mem[Addr[AW+1:2]] : !io_sel ? '0 :
               off == 2'd0 ? out_data : off == 2'd1 ? status : off == 2'd2 ? cyc_q : '0;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    cyc_d = wr_cyc ? WriteData : cyc_q + 1'b1;
    // set wins over a same-edge W1C clear
    err_d[0] = (err_q[0] & ~(wr_stat & WriteData[2])) | unm_set;
    err_d[1] = (err_q[1] & ~(wr_stat & WriteData[3])) | (push_try & full);
  end
  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel) mem[Addr[AW+1:2]] <= WriteData;
    if (push) fifo[wr_q] <= WriteData;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      cyc_q <= '0;
      err_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: scenario tasks with a FIFO scoreboard queue for data_bus_responder.
module tb_data_bus_responder;
  localparam logic [31:0] IO = 32'h0000_1000;
  localparam logic [31:0] ST = 32'h0000_1004;
  localparam logic [31:0] CY = 32'h0000_1008;
  logic clk = 0, rst = 1, MemWrite = 0, out_ready = 0, out_valid;
  logic [31:0] Addr = 0, WriteData = 0, ReadData, out_data, v;
  logic [31:0] sb [$];
  int passed = 0, total = 0;

  data_bus_responder dut (.clk(clk), .rst(rst), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1; Addr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Addr = a; #1; d = ReadData;
  endtask

  task automatic push(input logic [31:0] d);
    if (sb.size() < 8) sb.push_back(d);
    wr(IO, d);
  endtask

  task automatic drain(input int n, input string tag);
    out_ready = 1;
    for (int i = 0; i < n; i++) begin
      #1; total++;
      if (!out_valid || sb.size() == 0) $display("FAIL %s pop%0d: out_valid=%b queue=%0d", tag, i, out_valid, sb.size());
      else begin
        v = sb.pop_front();
        if (out_data !== v) $display("FAIL %s pop%0d: got %h want %h", tag, i, out_data, v);
        else passed++;
      end
      @(negedge clk);
    end
    out_ready = 0;
  endtask

  task automatic test_reset;
    #1; total++;
    if (out_valid !== 0 || out_data !== 0) $display("FAIL reset_out: valid=%b data=%h want 0/0", out_valid, out_data); else passed++;
    rd(ST, v); total++;
    if (v !== 32'h1) $display("FAIL reset_status: got %h want 00000001", v); else passed++;
    rd(CY, v); total++;
    if (v !== 0) $display("FAIL reset_cycles: got %h want 0", v); else passed++;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_ram;
    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h14, 32'h0);
    rd(32'h10, v); total++;
    if (v !== 32'hDEAD_BEEF) $display("FAIL ram_10: got %h want deadbeef", v); else passed++;
    rd(32'h14, v); total++;
    if (v !== 0) $display("FAIL ram_14: got %h want 0", v); else passed++;
    wr(32'hFC, 32'h1234_5678);
    rd(32'hFC, v); total++;
    if (v !== 32'h1234_5678) $display("FAIL ram_top: got %h want 12345678", v); else passed++;
    @(negedge clk);
  endtask

  task automatic test_fifo_order;
    MemWrite = 1; Addr = IO; WriteData = 32'h11; sb.push_back(32'h11);
    #1; total++;
    if (out_valid !== 0) $display("FAIL fifo_latency0: out_valid=%b want 0", out_valid); else passed++;
    @(negedge clk); #1; total++;
    if (out_valid !== 1 || out_data !== 32'h11) $display("FAIL fifo_latency1: valid=%b data=%h want 1/11", out_valid, out_data); else passed++;
    MemWrite = 0;
    push(32'h22);
    push(32'h33);
    rd(ST, v); total++;
    if (v !== 32'h0000_0300) $display("FAIL fifo_status3: got %h want 00000300", v); else passed++;
    drain(3, "fifo_order");
    rd(ST, v); total++;
    if (v !== 32'h1) $display("FAIL fifo_status_empty: got %h want 00000001", v); else passed++;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 9; i++) push(32'hA0 + i);
    rd(ST, v); total++;
    if (v !== 32'h0000_080A) $display("FAIL ovf_status: got %h want 0000080a", v); else passed++;
    rd(IO, v); total++;
    if (v !== 32'hA0) $display("FAIL ovf_peek: got %h want 000000a0", v); else passed++;
    wr(ST, 32'h8);
    rd(ST, v); total++;
    if (v !== 32'h0000_0802) $display("FAIL ovf_w1c: got %h want 00000802", v); else passed++;
    drain(8, "ovf_drain");
    rd(ST, v); total++;
    if (v !== 32'h1 || sb.size() != 0) $display("FAIL ovf_empty: status %h want 00000001, queue %0d", v, sb.size()); else passed++;
  endtask

  task automatic test_unmapped;
    wr(32'h800, 32'h5555_5555);
    rd(ST, v); total++;
    if (v !== 32'h5) $display("FAIL unm_set: got %h want 00000005", v); else passed++;
    rd(32'h800, v); total++;
    if (v !== 0) $display("FAIL unm_read: got %h want 0", v); else passed++;
    wr(ST, 32'h4);
    rd(ST, v); total++;
    if (v !== 32'h1) $display("FAIL unm_clear: got %h want 00000001", v); else passed++;
    wr(32'h100C, 32'h1);
    rd(32'h100C, v); total++;
    if (v !== 0) $display("FAIL rsv_read: got %h want 0", v); else passed++;
    rd(ST, v); total++;
    if (v !== 32'h5) $display("FAIL rsv_set: got %h want 00000005", v); else passed++;
    wr(ST, 32'hC);
    @(negedge clk);
  endtask

  task automatic test_cycles;
    wr(CY, 32'hFFFF_FFFE);
    rd(CY, v); total++;
    if (v !== 32'hFFFF_FFFE) $display("FAIL cyc_load: got %h want fffffffe", v); else passed++;
    @(negedge clk); rd(CY, v); total++;
    if (v !== 32'hFFFF_FFFF) $display("FAIL cyc_inc: got %h want ffffffff", v); else passed++;
    @(negedge clk); rd(CY, v); total++;
    if (v !== 0) $display("FAIL cyc_wrap: got %h want 0", v); else passed++;
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(32'hC0 + i);
    out_ready = 1;
    #2 rst = 1;
    #1; total++;
    if (out_valid !== 0) $display("FAIL rst_async: out_valid=%b want 0", out_valid); else passed++;
    sb.delete();
    @(negedge clk); rst = 0; out_ready = 0;
    rd(ST, v); total++;
    if (v !== 32'h1) $display("FAIL rst_status: got %h want 00000001", v); else passed++;
    rd(CY, v); total++;
    if (v !== 0) $display("FAIL rst_cyc0: got %h want 0", v); else passed++;
    rd(32'h10, v); total++;
    if (v !== 32'hDEAD_BEEF) $display("FAIL rst_ram: got %h want deadbeef", v); else passed++;
    @(negedge clk); rd(CY, v); total++;
    if (v !== 1) $display("FAIL rst_cyc1: got %h want 1", v); else passed++;
  endtask

  initial begin
    test_reset;
    test_ram;
    test_fifo_order;
    test_overflow;
    test_unmapped;
    test_cycles;
    test_reset_midstream;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
